// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters. Conflicts are resolved
// round-robin. The ALU result and zero flag are captured into a one-entry
// response slot that is tagged with its owner, and the slot is returned over a
// valid/ready handshake. When responses are drained promptly, the block
// sustains one operation per cycle.
//
// Ports
//   clk, rst_n                rising-edge clock, async active-low reset
//   rqX_valid/ready           request handshake, port X (0 or 1)
//   rqX_a/b/op                request operands and ALU control code
//   rsX_valid/ready           response handshake, port X
//   rsX_result/zero           response payload (both ports see the slot)
//   alu_a/b/control           drive to the shared ALU (zero when idle)
//   alu_result/zero           ALU outputs, captured on a grant
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic [DATA_W-1:0] rq0_a,
    input  logic [DATA_W-1:0] rq0_b,
    input  logic [OP_W-1:0]   rq0_op,
    output logic              rs0_valid,
    input  logic              rs0_ready,
    output logic [DATA_W-1:0] rs0_result,
    output logic              rs0_zero,

    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic [DATA_W-1:0] rq1_a,
    input  logic [DATA_W-1:0] rq1_b,
    input  logic [OP_W-1:0]   rq1_op,
    output logic              rs1_valid,
    input  logic              rs1_ready,
    output logic [DATA_W-1:0] rs1_result,
    output logic              rs1_zero,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;

    logic can_issue;
    logic gnt_vld;
    logic gnt_id;

    // Grant and ALU drive
    always_comb begin
        can_issue = (state_q == StEmpty) || (owner_q ? rs1_ready : rs0_ready);
        gnt_vld   = 1'b0;
        gnt_id    = 1'b0;
        // rst_n gating keeps both readies low while reset is held
        if (rst_n && can_issue) begin
            if (rq0_valid && rq1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = ~last_grant_q;
            end else if (rq0_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b0;
            end else if (rq1_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end

        rq0_ready = gnt_vld & ~gnt_id;
        rq1_ready = gnt_vld & gnt_id;

        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        if (gnt_vld) begin
            alu_a       = gnt_id ? rq1_a  : rq0_a;
            alu_b       = gnt_id ? rq1_b  : rq0_b;
            alu_control = gnt_id ? rq1_op : rq0_op;
        end
    end

    // Slot next state. A grant is only possible when the held response (if any)
    // is retiring this cycle, so drain-and-refill leaves the slot FULL.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        zero_d       = zero_q;
        if (gnt_vld) begin
            state_d      = StFull;
            owner_d      = gnt_id;
            last_grant_d = gnt_id;
            result_d     = alu_result;
            zero_d       = alu_zero;
        end else if (state_q == StFull && (owner_q ? rs1_ready : rs0_ready)) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    always_comb begin
        rs0_valid  = (state_q == StFull) && !owner_q;
        rs1_valid  = (state_q == StFull) && owner_q;
        rs0_result = result_q;
        rs1_result = result_q;
        rs0_zero   = zero_q;
        rs1_zero   = zero_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpSub  = 5'd1;
    localparam logic [4:0] OpSll  = 5'd2;
    localparam logic [4:0] OpSrl  = 5'd3;
    localparam logic [4:0] OpSra  = 5'd4;
    localparam logic [4:0] OpSltu = 5'd5;
    localparam logic [4:0] OpOr   = 5'd6;
    localparam logic [4:0] OpAnd  = 5'd7;

    logic        clk;
    logic        rst_n;
    logic        rq0_valid, rq0_ready, rs0_valid, rs0_ready, rs0_zero;
    logic        rq1_valid, rq1_ready, rs1_valid, rs1_ready, rs1_zero;
    logic [31:0] rq0_a, rq0_b, rq1_a, rq1_b, rs0_result, rs1_result;
    logic [4:0]  rq0_op, rq1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_control;
    logic        alu_zero;

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter #(.DATA_W(32), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_a(rq0_a), .rq0_b(rq0_b),
        .rq0_op(rq0_op), .rs0_valid(rs0_valid), .rs0_ready(rs0_ready),
        .rs0_result(rs0_result), .rs0_zero(rs0_zero),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_a(rq1_a), .rq1_b(rq1_b),
        .rq1_op(rq1_op), .rs1_valid(rs1_valid), .rs1_ready(rs1_ready),
        .rs1_result(rs1_result), .rs1_zero(rs1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpSll:   return a << b[4:0];
            OpSrl:   return a >> b[4:0];
            OpSra:   return $unsigned($signed(a) >>> b[4:0]);
            OpSltu:  return (a < b) ? 32'd1 : 32'd0;
            OpOr:    return a | b;
            OpAnd:   return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural stand-in for the shared ALU
    always_comb begin
        alu_result = alu_f(alu_a, alu_b, alu_control);
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        rq0_valid = 0; rq1_valid = 0;
        rq0_a = 0; rq0_b = 0; rq0_op = 0;
        rq1_a = 0; rq1_b = 0; rq1_op = 0;
        rs0_ready = 1; rs1_ready = 1;
    endtask

    task automatic do_reset();
        set_idle();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0;
        logic [4:0]  op0;
        logic [31:0] a1, b1;
        logic [4:0]  op1;
        logic        rr0, rr1;
        logic        er0, er1, ev0, ev1;
        logic [31:0] eres;
        logic        ez;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: one optional held response plus the last winner
    bit          m_full;
    int          m_owner;
    int          m_last;
    logic [31:0] m_res;
    logic        m_zero;

    function automatic int model_grant();
        bit can;
        can = !m_full || (m_owner == 0 ? rs0_ready : rs1_ready);
        if (!can) return -1;
        if (rq0_valid && rq1_valid) return 1 - m_last;
        if (rq0_valid) return 0;
        if (rq1_valid) return 1;
        return -1;
    endfunction

    initial begin
        rst_n = 0;
        set_idle();

        // Directed table; expected values sampled mid-cycle
        //            v0 v1  a0           b0     op0     a1     b1     op1    rr0 rr1 er0 er1 ev0 ev1 eres          ez
        tbl.push_back('{0, 0, 0,           0,     OpAdd,  0,     0,     OpAdd, 1, 1, 0, 0, 0, 0, 32'h0,       0});
        for (int k = 0; k < 8; k++) begin
            vec_t r;
            r = '{1, 1, 9, 9, OpSub, 32'h0F, 32'hF0, OpOr, 1, 1, 0, 0, 0, 0, 32'h0, 0};
            r.er0 = (k % 2 == 0);
            r.er1 = (k % 2 == 1);
            r.ev0 = (k > 0) && (k % 2 == 1);
            r.ev1 = (k > 0) && (k % 2 == 0);
            r.eres = r.ev1 ? 32'hFF : 32'h0;
            r.ez   = r.ev0;
            tbl.push_back(r);
        end
        tbl.push_back('{0, 0, 0,           0,     OpAdd,  0,     0,     OpAdd, 1, 1, 0, 0, 0, 1, 32'hFF,      0});
        tbl.push_back('{1, 0, 5,           7,     OpAdd,  0,     0,     OpAdd, 1, 1, 1, 0, 0, 0, 32'h0,       0});
        tbl.push_back('{0, 0, 0,           0,     OpAdd,  0,     0,     OpAdd, 1, 1, 0, 0, 1, 0, 32'd12,      0});
        tbl.push_back('{0, 1, 0,           0,     OpAdd,  32'h0F,32'hF0,OpOr,  1, 0, 0, 1, 0, 0, 32'h0,       0});
        tbl.push_back('{1, 0, 5,           7,     OpAdd,  0,     0,     OpAdd, 1, 0, 0, 0, 0, 1, 32'hFF,      0});
        tbl.push_back('{1, 0, 5,           7,     OpAdd,  0,     0,     OpAdd, 1, 0, 0, 0, 0, 1, 32'hFF,      0});
        tbl.push_back('{1, 0, 5,           7,     OpAdd,  0,     0,     OpAdd, 1, 0, 0, 0, 0, 1, 32'hFF,      0});
        tbl.push_back('{1, 0, 5,           7,     OpAdd,  0,     0,     OpAdd, 1, 1, 1, 0, 0, 1, 32'hFF,      0});
        tbl.push_back('{0, 0, 0,           0,     OpAdd,  0,     0,     OpAdd, 1, 1, 0, 0, 1, 0, 32'd12,      0});
        tbl.push_back('{1, 0, 1,           4,     OpSll,  0,     0,     OpAdd, 1, 1, 1, 0, 0, 0, 32'h0,       0});
        tbl.push_back('{1, 0, 32'h80000000,4,     OpSra,  0,     0,     OpAdd, 1, 1, 1, 0, 1, 0, 32'h10,      0});
        tbl.push_back('{1, 0, 1,           2,     OpSltu, 0,     0,     OpAdd, 1, 1, 1, 0, 1, 0, 32'hF8000000,0});
        tbl.push_back('{1, 0, 32'hF0,      32'h3C,OpAnd,  0,     0,     OpAdd, 1, 1, 1, 0, 1, 0, 32'h1,       0});
        tbl.push_back('{0, 0, 0,           0,     OpAdd,  0,     0,     OpAdd, 1, 1, 0, 0, 1, 0, 32'h30,      0});
        tbl.push_back('{0, 0, 0,           0,     OpAdd,  0,     0,     OpAdd, 1, 1, 0, 0, 0, 0, 32'h0,       0});

        #2;
        @(negedge clk);
        chk("reset_rs0_valid", {31'd0, rs0_valid}, 0);
        chk("reset_rs1_valid", {31'd0, rs1_valid}, 0);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            rq0_valid = tbl[i].v0; rq0_a = tbl[i].a0; rq0_b = tbl[i].b0; rq0_op = tbl[i].op0;
            rq1_valid = tbl[i].v1; rq1_a = tbl[i].a1; rq1_b = tbl[i].b1; rq1_op = tbl[i].op1;
            rs0_ready = tbl[i].rr0; rs1_ready = tbl[i].rr1;
            @(negedge clk);
            chk($sformatf("tbl%0d_rq0_ready", i), {31'd0, rq0_ready}, {31'd0, tbl[i].er0});
            chk($sformatf("tbl%0d_rq1_ready", i), {31'd0, rq1_ready}, {31'd0, tbl[i].er1});
            chk($sformatf("tbl%0d_rs0_valid", i), {31'd0, rs0_valid}, {31'd0, tbl[i].ev0});
            chk($sformatf("tbl%0d_rs1_valid", i), {31'd0, rs1_valid}, {31'd0, tbl[i].ev1});
            chk($sformatf("tbl%0d_alu_a", i), alu_a,
                tbl[i].er0 ? tbl[i].a0 : (tbl[i].er1 ? tbl[i].a1 : 32'd0));
            chk($sformatf("tbl%0d_alu_control", i), {27'd0, alu_control},
                {27'd0, tbl[i].er0 ? tbl[i].op0 : (tbl[i].er1 ? tbl[i].op1 : 5'd0)});
            if (tbl[i].ev0 || tbl[i].ev1) begin
                chk($sformatf("tbl%0d_result", i), tbl[i].ev1 ? rs1_result : rs0_result,
                    tbl[i].eres);
                chk($sformatf("tbl%0d_zero", i), {31'd0, tbl[i].ev1 ? rs1_zero : rs0_zero},
                    {31'd0, tbl[i].ez});
            end
            @(posedge clk);
            #1;
        end

        // Reset while a response is held
        set_idle();
        rq0_valid = 1; rq0_a = 5; rq0_b = 7; rq0_op = OpAdd; rs0_ready = 0;
        @(posedge clk);
        #1;
        rq0_valid = 0;
        @(negedge clk);
        chk("rstmid_full_rs0_valid", {31'd0, rs0_valid}, 1);
        #2;
        rst_n = 0;
        rq0_valid = 1; rq1_valid = 1;
        #1;
        chk("rstmid_rs0_valid", {31'd0, rs0_valid}, 0);
        chk("rstmid_rs1_valid", {31'd0, rs1_valid}, 0);
        chk("rstmid_rq0_ready", {31'd0, rq0_ready}, 0);
        chk("rstmid_rq1_ready", {31'd0, rq1_ready}, 0);
        @(posedge clk);
        #1;
        set_idle();
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rstpost_rs0_valid", {31'd0, rs0_valid}, 0);
            chk("rstpost_rs1_valid", {31'd0, rs1_valid}, 0);
            @(posedge clk);
            #1;
        end
        rq0_valid = 1; rq0_a = 9; rq0_b = 9; rq0_op = OpSub;
        rq1_valid = 1; rq1_a = 32'h0F; rq1_b = 32'hF0; rq1_op = OpOr;
        @(negedge clk);
        chk("rstpost_tie_rq0_ready", {31'd0, rq0_ready}, 1);
        chk("rstpost_tie_rq1_ready", {31'd0, rq1_ready}, 0);
        @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
        chk("rstpost_rs0_valid_new", {31'd0, rs0_valid}, 1);
        chk("rstpost_rs0_zero", {31'd0, rs0_zero}, 1);

        // Randomised traffic against the reference model
        do_reset();
        m_full = 0; m_owner = 0; m_last = 1; m_res = 0; m_zero = 0;
        for (int c = 0; c < 400; c++) begin
            int g;
            @(negedge clk);
            g = model_grant();
            chk("rnd_rq0_ready", {31'd0, rq0_ready}, {31'd0, g == 0});
            chk("rnd_rq1_ready", {31'd0, rq1_ready}, {31'd0, g == 1});
            chk("rnd_alu_a", alu_a, g == 0 ? rq0_a : (g == 1 ? rq1_a : 32'd0));
            chk("rnd_alu_b", alu_b, g == 0 ? rq0_b : (g == 1 ? rq1_b : 32'd0));
            chk("rnd_alu_control", {27'd0, alu_control},
                {27'd0, g == 0 ? rq0_op : (g == 1 ? rq1_op : 5'd0)});
            chk("rnd_rs0_valid", {31'd0, rs0_valid}, {31'd0, m_full && m_owner == 0});
            chk("rnd_rs1_valid", {31'd0, rs1_valid}, {31'd0, m_full && m_owner == 1});
            if (m_full) begin
                chk("rnd_result", m_owner == 1 ? rs1_result : rs0_result, m_res);
                chk("rnd_zero", {31'd0, m_owner == 1 ? rs1_zero : rs0_zero}, {31'd0, m_zero});
            end
            @(posedge clk);
            #1;
            if (g >= 0) begin
                m_res   = (g == 0) ? alu_f(rq0_a, rq0_b, rq0_op) : alu_f(rq1_a, rq1_b, rq1_op);
                m_zero  = (m_res == 32'd0);
                m_full  = 1;
                m_owner = g;
                m_last  = g;
            end else if (m_full && (m_owner == 0 ? rs0_ready : rs1_ready)) begin
                m_full = 0;
            end
            // A pending request stays stable until it is accepted
            if (!rq0_valid || g == 0) begin
                rq0_valid = ($urandom_range(2) != 0);
                rq0_a  = $urandom_range(3) == 0 ? rq0_b : $urandom;
                rq0_b  = $urandom;
                rq0_op = 5'($urandom_range(7));
            end
            if (!rq1_valid || g == 1) begin
                rq1_valid = ($urandom_range(2) != 0);
                rq1_a  = $urandom;
                rq1_b  = $urandom_range(3) == 0 ? rq1_a : $urandom;
                rq1_op = 5'($urandom_range(7));
            end
            rs0_ready = ($urandom_range(3) != 0);
            rs1_ready = ($urandom_range(3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the integer execute stage (port 0) and the address/branch-compare helper (port 1).
- Arbitrates round-robin and drives the ALU operand and control inputs from the winner.
- Registers the ALU result and zero flag into a one-entry response slot tagged with the owner.
- Returns the response over a valid/ready handshake, sustaining one operation per cycle when responses are drained promptly.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 5, ALU control code width (00000=ADD … 00111=AND).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rq0_valid  in  1  port 0 request valid.
- rq0_ready  out  1  port 0 request accepted this cycle.
- rq0_a  in  DATA_W  port 0 operand a.
- rq0_b  in  DATA_W  port 0 operand b.
- rq0_op  in  OP_W  port 0 ALU control code.
- rs0_valid  out  1  port 0 response valid.
- rs0_ready  in  1  port 0 response accept.
- rs0_result  out  DATA_W  port 0 result.
- rs0_zero  out  1  port 0 zero flag.
- rq1_*, rs1_*  (same set, port 1).
- alu_a  out  DATA_W  to ALU operand a.
- alu_b  out  DATA_W  to ALU operand b.
- alu_control  out  OP_W  to ALU control.
- alu_result  in  DATA_W  from ALU result.
- alu_zero  in  1  from ALU zero.

Behaviour:
- Reset (async, rst_n=0): state=EMPTY, owner=0, last_grant=1 (port 0 wins first tie), slot result=0, zero=0. All rsX_valid=0 and rqX_ready=0 while in reset.
- States:
  - EMPTY: no response held.
  - FULL: response held for owner.
- can_issue = (state==EMPTY) | (state==FULL & rs<owner>_ready).
- Grant (combinational):
  - If can_issue and only one rqX_valid, grant X.
  - If both valid, grant the port != last_grant.
  - Else no grant.
  - rqX_ready=1 only for the granted port; at most one ready per cycle.
- ALU drive:
  - On grant: alu_a/alu_b/alu_control = granted port's a/b/op.
  - No grant: all driven 0 (ADD of zeros), for deterministic values.
- On grant clock edge:
  - slot <= {alu_result, alu_zero}, owner <= X, last_grant <= X, state <= FULL.
- FULL, rs<owner>_ready=1, no grant: state <= EMPTY.
- FULL, rs<owner>_ready=0: slot, owner and state hold; no requests accepted (backpressure).
- Simultaneous drain and grant: response retires and new result loads on the same edge; state stays FULL.
- Latency: rsX_valid is high the cycle after rqX_ready (1 cycle). Back-to-back throughput is 1/cycle.
- rsX_valid = (state==FULL) & (owner==X).
- rsX_result/rsX_zero:
  - Both ports' outputs see the slot contents.
  - Only meaningful when that port's valid is high.
- Requester rules:
  - Hold valid/a/b/op stable until ready.
  - rqX_ready may depend on both valids (combinational path); requesters must not make valid depend on ready.
- Fairness: with both ports continuously valid and responses drained every cycle, grants strictly alternate 0,1,0,1…
- A port whose response is stalled blocks both ports. This is intentional; single slot.
- Zero flag: taken from alu_zero, never recomputed.
- Reset mid-operation: the held response is discarded; no rsX_valid after reset until a new grant.

Test Plan:
- Single request: rq0 valid, a=5, b=7, op=00000 with rs0_ready=1 → rq0_ready same cycle; next cycle rs0_valid=1, result=12, zero=0; rs1_valid stays 0.
- Tie after reset: both valid (rq0 SUB 9-9, rq1 OR 0x0F|0xF0) → rq0 granted first: result 0, zero=1. Then rq1 granted: result 0xFF. Grants alternate over 8 cycles of continuous requests.
- Backpressure: rs1_ready=0 for 3 cycles with a response held; rq0 valid → rq0_ready=0 and slot unchanged for all 3 cycles. When rs1_ready=1, rq0 is accepted that same cycle and rs0_valid=1 the next.
- Throughput: rq0 streams 4 ops (SLL 1<<4, SRA 0x80000000>>>4, SLTU 1<2, AND 0xF0&0x3C) with rs0_ready=1 → responses on 4 consecutive cycles: 0x10, 0xF8000000, 1, 0x30.
- Reset mid-op: assert rst_n=0 while FULL → rs0_valid/rs1_valid drop asynchronously. After release, no valid appears until a new request; the first tie goes to port 0.
- Idle: no valids → alu_a=alu_b=0, alu_control=0, all ready/valid low.
